// File: rtl/fetch_sequencer.sv
// Program counter and fetch sequencer feeding the instruction ROM address.
// Handles start/halt, jump/branch/stall updates and a saturating cycle counter.
module fetch_sequencer #(
   parameter int A          = 12,
   parameter int OFFW       = 8,
   parameter int CNTW       = 16,
   parameter int START_ADDR = 0
) (
   input  logic            Clk,
   input  logic            Reset,
   input  logic            Start,
   input  logic            Halt,
   input  logic            Stall,
   input  logic            JumpEn,
   input  logic [A-1:0]    JumpTarget,
   input  logic            BranchEn,
   input  logic [OFFW-1:0] BranchOff,
   output logic [A-1:0]    InstAddress,
   output logic            Running,
   output logic            Done,
   output logic [CNTW-1:0] CycleCount
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_HALT = 2'd2;

   localparam logic [A-1:0] PC_START = A'(START_ADDR);

   logic [1:0]      state_q, state_d;
   logic [A-1:0]    pc_q, pc_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic [A-1:0]    off_ext;

   assign off_ext = A'($signed(BranchOff));

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE, S_HALT: begin
            if (Start) begin
               state_d = S_RUN;
               pc_d    = PC_START;
               cnt_d   = '0;
            end
         end
         S_RUN: begin
            // halt and stall cycles are counted too
            if (cnt_q != '1) cnt_d = cnt_q + CNTW'(1);
            if (Halt) begin
               state_d = S_HALT;
            end else if (Stall) begin
               pc_d = pc_q;
            end else if (JumpEn) begin
               pc_d = JumpTarget;
            end else if (BranchEn) begin
               pc_d = pc_q + off_ext;
            end else begin
               pc_d = pc_q + A'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            pc_d    = PC_START;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= S_IDLE;
         pc_q    <= PC_START;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
      end
   end

   assign InstAddress = pc_q;
   assign Running     = (state_q == S_RUN);
   assign Done        = (state_q == S_HALT);
   assign CycleCount  = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer; a second narrow-counter instance
// shares the stimulus to exercise counter saturation.
module tb_fetch_sequencer;

   logic        Clk;
   logic        Reset;
   logic        Start;
   logic        Halt;
   logic        Stall;
   logic        JumpEn;
   logic [11:0] JumpTarget;
   logic        BranchEn;
   logic [7:0]  BranchOff;
   logic [11:0] InstAddress;
   logic        Running;
   logic        Done;
   logic [15:0] CycleCount;
   logic [11:0] InstAddress_s;
   logic        Running_s;
   logic        Done_s;
   logic [3:0]  CycleCount_s;

   int errors = 0;
   int checks = 0;

   fetch_sequencer dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Halt(Halt),
      .Stall(Stall), .JumpEn(JumpEn), .JumpTarget(JumpTarget),
      .BranchEn(BranchEn), .BranchOff(BranchOff),
      .InstAddress(InstAddress), .Running(Running), .Done(Done),
      .CycleCount(CycleCount)
   );

   fetch_sequencer #(.CNTW(4)) dut_s (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Halt(Halt),
      .Stall(Stall), .JumpEn(JumpEn), .JumpTarget(JumpTarget),
      .BranchEn(BranchEn), .BranchOff(BranchOff),
      .InstAddress(InstAddress_s), .Running(Running_s), .Done(Done_s),
      .CycleCount(CycleCount_s)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic clear_in();
      Start = 0; Halt = 0; Stall = 0; JumpEn = 0;
      BranchEn = 0; JumpTarget = '0; BranchOff = '0;
   endtask

   task automatic test_reset();
      Reset = 1;
      clear_in();
      tick(); tick();
      checks++; if (InstAddress !== 12'd0) begin errors++; $display("FAIL rst_pc got=%0d exp=0", InstAddress); end
      checks++; if (Running !== 1'b0) begin errors++; $display("FAIL rst_running got=%b exp=0", Running); end
      checks++; if (Done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b exp=0", Done); end
      checks++; if (CycleCount !== 16'd0) begin errors++; $display("FAIL rst_cnt got=%0d exp=0", CycleCount); end
      Reset = 0;
      JumpEn = 1; JumpTarget = 12'd5; BranchEn = 1; BranchOff = 8'd3; Stall = 1; Halt = 1;
      tick(); tick();
      checks++; if (InstAddress !== 12'd0) begin errors++; $display("FAIL idle_pc got=%0d exp=0", InstAddress); end
      checks++; if (Running !== 1'b0 || Done !== 1'b0) begin errors++; $display("FAIL idle_state got=%b%b exp=00", Running, Done); end
      checks++; if (CycleCount !== 16'd0) begin errors++; $display("FAIL idle_cnt got=%0d exp=0", CycleCount); end
      clear_in();
   endtask

   task automatic test_sequential();
      Start = 1;
      tick();
      Start = 0;
      checks++; if (Running !== 1'b1) begin errors++; $display("FAIL start_running got=%b exp=1", Running); end
      checks++; if (InstAddress !== 12'd0) begin errors++; $display("FAIL start_pc got=%0d exp=0", InstAddress); end
      checks++; if (CycleCount !== 16'd0) begin errors++; $display("FAIL start_cnt got=%0d exp=0", CycleCount); end
      for (int i = 1; i <= 5; i++) begin
         tick();
         checks++; if (InstAddress !== 12'(i)) begin errors++; $display("FAIL seq_pc got=%0d exp=%0d", InstAddress, i); end
      end
      checks++; if (CycleCount !== 16'd5) begin errors++; $display("FAIL seq_cnt got=%0d exp=5", CycleCount); end
      checks++; if (CycleCount_s !== 4'd5) begin errors++; $display("FAIL seq_cnt_s got=%0d exp=5", CycleCount_s); end
      Start = 1;
      tick();
      Start = 0;
      checks++; if (InstAddress !== 12'd6) begin errors++; $display("FAIL run_start_pc got=%0d exp=6", InstAddress); end
      checks++; if (CycleCount !== 16'd6) begin errors++; $display("FAIL run_start_cnt got=%0d exp=6", CycleCount); end
   endtask

   task automatic test_branch();
      repeat (4) tick();
      checks++; if (InstAddress !== 12'd10) begin errors++; $display("FAIL pre_br_pc got=%0d exp=10", InstAddress); end
      BranchEn = 1; BranchOff = 8'hFC;
      tick();
      checks++; if (InstAddress !== 12'd6) begin errors++; $display("FAIL br_neg got=%0d exp=6", InstAddress); end
      BranchOff = 8'h7F;
      tick();
      checks++; if (InstAddress !== 12'd133) begin errors++; $display("FAIL br_pos got=%0d exp=133", InstAddress); end
      clear_in();
   endtask

   task automatic test_jump_priority();
      JumpEn = 1; JumpTarget = 12'd20;
      tick();
      checks++; if (InstAddress !== 12'd20) begin errors++; $display("FAIL jmp20 got=%0d exp=20", InstAddress); end
      JumpTarget = 12'd300; BranchEn = 1; BranchOff = 8'd5;
      tick();
      checks++; if (InstAddress !== 12'd300) begin errors++; $display("FAIL jmp_over_br got=%0d exp=300", InstAddress); end
      clear_in();
   endtask

   task automatic test_stall_wrap();
      JumpEn = 1; JumpTarget = 12'd7;
      tick();
      clear_in();
      checks++; if (InstAddress !== 12'd7) begin errors++; $display("FAIL jmp7 got=%0d exp=7", InstAddress); end
      checks++; if (CycleCount !== 16'd15) begin errors++; $display("FAIL pre_stall_cnt got=%0d exp=15", CycleCount); end
      Stall = 1; JumpEn = 1; JumpTarget = 12'd99;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (InstAddress !== 12'd7) begin errors++; $display("FAIL stall_pc got=%0d exp=7", InstAddress); end
      end
      checks++; if (CycleCount !== 16'd18) begin errors++; $display("FAIL stall_cnt got=%0d exp=18", CycleCount); end
      checks++; if (CycleCount_s !== 4'd15) begin errors++; $display("FAIL sat_cnt_s got=%0d exp=15", CycleCount_s); end
      Stall = 0; JumpTarget = 12'hFFF;
      tick();
      clear_in();
      checks++; if (InstAddress !== 12'hFFF) begin errors++; $display("FAIL jmp_fff got=%0d exp=4095", InstAddress); end
      tick();
      checks++; if (InstAddress !== 12'd0) begin errors++; $display("FAIL inc_wrap got=%0d exp=0", InstAddress); end
      checks++; if (CycleCount !== 16'd20) begin errors++; $display("FAIL wrap_cnt got=%0d exp=20", CycleCount); end
      BranchEn = 1; BranchOff = 8'hFF;
      tick();
      checks++; if (InstAddress !== 12'hFFF) begin errors++; $display("FAIL br_m1_wrap got=%0d exp=4095", InstAddress); end
      BranchOff = 8'h01;
      tick();
      checks++; if (InstAddress !== 12'd0) begin errors++; $display("FAIL br_p1_wrap got=%0d exp=0", InstAddress); end
      checks++; if (CycleCount_s !== 4'd15) begin errors++; $display("FAIL sat_hold_s got=%0d exp=15", CycleCount_s); end
      clear_in();
   endtask

   task automatic test_halt();
      Reset = 1;
      tick();
      Reset = 0;
      Start = 1;
      tick();
      Start = 0;
      repeat (42) tick();
      checks++; if (InstAddress !== 12'd42) begin errors++; $display("FAIL pre_halt_pc got=%0d exp=42", InstAddress); end
      Halt = 1; Stall = 1; JumpEn = 1; JumpTarget = 12'd99;
      tick();
      Halt = 0; Stall = 0; BranchEn = 1; BranchOff = 8'd9;
      checks++; if (Done !== 1'b1 || Running !== 1'b0) begin errors++; $display("FAIL halt_state got=%b%b exp=10", Done, Running); end
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++; if (InstAddress !== 12'd42) begin errors++; $display("FAIL halt_pc got=%0d exp=42", InstAddress); end
         checks++; if (CycleCount !== 16'd43) begin errors++; $display("FAIL halt_cnt got=%0d exp=43", CycleCount); end
         checks++; if (Done !== 1'b1 || Running !== 1'b0) begin errors++; $display("FAIL halt_hold got=%b%b exp=10", Done, Running); end
      end
      checks++; if (CycleCount_s !== 4'd15) begin errors++; $display("FAIL halt_cnt_s got=%0d exp=15", CycleCount_s); end
      clear_in();
      Start = 1;
      tick();
      Start = 0;
      checks++; if (InstAddress !== 12'd0) begin errors++; $display("FAIL restart_pc got=%0d exp=0", InstAddress); end
      checks++; if (CycleCount !== 16'd0) begin errors++; $display("FAIL restart_cnt got=%0d exp=0", CycleCount); end
      checks++; if (CycleCount_s !== 4'd0) begin errors++; $display("FAIL restart_cnt_s got=%0d exp=0", CycleCount_s); end
      checks++; if (Done !== 1'b0 || Running !== 1'b1) begin errors++; $display("FAIL restart_state got=%b%b exp=01", Done, Running); end
   endtask

   task automatic test_async_reset();
      repeat (55) tick();
      checks++; if (InstAddress !== 12'd55) begin errors++; $display("FAIL pre_rst_pc got=%0d exp=55", InstAddress); end
      #2;
      Reset = 1; Start = 1;
      #1;
      checks++; if (InstAddress !== 12'd0) begin errors++; $display("FAIL arst_pc got=%0d exp=0", InstAddress); end
      checks++; if (Running !== 1'b0 || Done !== 1'b0) begin errors++; $display("FAIL arst_state got=%b%b exp=00", Running, Done); end
      checks++; if (CycleCount !== 16'd0) begin errors++; $display("FAIL arst_cnt got=%0d exp=0", CycleCount); end
      tick(); tick();
      checks++; if (Running !== 1'b0 || InstAddress !== 12'd0) begin errors++; $display("FAIL rst_start got=%b/%0d exp=0/0", Running, InstAddress); end
      Reset = 0; Start = 0;
      tick();
      checks++; if (Running !== 1'b0) begin errors++; $display("FAIL post_rst_idle got=%b exp=0", Running); end
      Start = 1;
      tick();
      Start = 0;
      tick();
      checks++; if (InstAddress !== 12'd1 || Running !== 1'b1) begin errors++; $display("FAIL post_rst_run got=%0d/%b exp=1/1", InstAddress, Running); end
   endtask

   initial begin
      clear_in();
      Reset = 1;
      test_reset();
      test_sequential();
      test_branch();
      test_jump_priority();
      test_stall_wrap();
      test_halt();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Program-counter and fetch sequencer that sits directly upstream of the 12-bit-address instruction ROM, driving its InstAddress input every cycle.
- Owns the start/halt handshake with the testbench or top level.
- Applies PC updates requested by the decode/branch logic: sequential increment, absolute jump, signed relative branch and stall.
- Counts executed cycles for performance reporting.

Parameters:
- A, 12, PC / instruction-address width; must match the ROM address width.
- OFFW, 8, width of the signed relative branch offset.
- CNTW, 16, width of the cycle counter.
- START_ADDR, 0, PC value loaded on reset and on Start.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Start  input  1  begin execution from START_ADDR; accepted only in IDLE or HALTED.
- Halt  input  1  current instruction is a halt; stop fetching.
- Stall  input  1  hold the PC this cycle.
- JumpEn  input  1  load JumpTarget into the PC.
- JumpTarget  input  A  absolute jump address.
- BranchEn  input  1  add BranchOff to the PC (branch taken).
- BranchOff  input  OFFW  signed two's-complement offset, relative to the current PC.
- InstAddress  output  A  current PC; drives the ROM address.
- Running  output  1  high while in RUN.
- Done  output  1  high while in HALTED.
- CycleCount  output  CNTW  number of cycles spent in RUN since the last Start.

Behaviour:
- States: IDLE, RUN, HALTED.
- Reset (asynchronous, any time, including mid-RUN):
  - state=IDLE, PC=START_ADDR, CycleCount=0, Running=0, Done=0.
  - Release takes effect at the next edge with no glitch on InstAddress.
- Outputs:
  - InstAddress is PC directly (registered, no combinational path from any input).
  - Running and Done are decoded from registered state.
- IDLE:
  - Start=1 -> RUN; PC=START_ADDR; CycleCount=0.
  - All other inputs are ignored.
- HALTED:
  - Done=1; PC holds at the halt instruction's address; CycleCount holds.
  - Start=1 -> RUN; PC=START_ADDR; CycleCount=0; Done drops on the following cycle.
- RUN, evaluated each edge in strict priority order:
  1. Halt=1 -> HALTED; PC unchanged. The halt cycle itself is counted.
  2. Stall=1 -> PC unchanged.
  3. JumpEn=1 -> PC=JumpTarget.
  4. BranchEn=1 -> PC = PC + sign-extended BranchOff.
  5. Otherwise PC = PC + 1.
- Start while in RUN: ignored; no restart.
- Arithmetic:
  - All PC arithmetic is modulo 2**A.
  - Increment at 2**A-1 wraps to 0.
  - A branch of -1 from 0 gives 2**A-1.
  - BranchOff is sign-extended from OFFW to A bits before the add.
- Simultaneous JumpEn and BranchEn: jump wins; the branch is dropped silently.
- Simultaneous Halt and Stall/Jump/Branch: Halt wins; PC holds.
- CycleCount:
  - +1 on every RUN-state edge, including stalled and halt cycles.
  - Saturates at 2**CNTW-1; never wraps.
  - Cleared only by Reset or an accepted Start.
- Latency:
  - A PC update requested in cycle n appears on InstAddress in cycle n+1.
  - The ROM is combinational, so the new instruction is valid in cycle n+1.

Test Plan:
- Reset, then Start pulse; no control inputs for 5 cycles -> InstAddress 0,1,2,3,4,5; Running=1; CycleCount=5.
- At PC=10, BranchEn=1 with BranchOff=8'hFC (-4) -> next PC=6. At PC=6, BranchOff=8'h7F -> PC=133.
- At PC=20, JumpEn=1 and BranchEn=1, JumpTarget=300, BranchOff=5 -> PC=300.
- Stall held 3 cycles at PC=7 -> PC stays 7; CycleCount still increments by 3. Then JumpTarget=12'hFFF and one free cycle -> PC=0 (wrap).
- Halt at PC=42 after 43 RUN cycles:
  - -> Done=1, Running=0, InstAddress=42, CycleCount=43, all held for 10 cycles.
  - Start then -> PC=0, CycleCount=0, Done=0.
- Assert Reset asynchronously mid-RUN at PC=55, between clock edges -> InstAddress=0, Running=0, Done=0 immediately; Start is ignored while Reset is high.
